// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The FSM state encoding and default bus widths are kept here so the top and bench agree.
package dmem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, and on a tie the
// master that was not granted last time wins. The output is one-hot.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port blockram between the CPU data port (m0) and the
// VGA/debug port (m1). Each transaction takes IDLE -> ISSUE -> RESP.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            resetn,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,

  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_rdata
);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic            cap_we_q, cap_we_d;
  logic [DW/8-1:0] cap_be_q, cap_be_d;
  logic [AW-1:0]   cap_addr_q, cap_addr_d;
  logic [DW-1:0]   cap_wdata_q, cap_wdata_d;
  logic [1:0]      pick;

  rr_arb2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .gnt  (pick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cap_we_q    <= 1'b0;
      cap_be_q    <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cap_we_q    <= cap_we_d;
      cap_be_q    <= cap_be_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  // Only the grant pulses depend on req; everything else comes from the captured copy.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cap_we_d    = cap_we_q;
    cap_be_d    = cap_be_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          m0_gnt      = pick[0];
          m1_gnt      = pick[1];
          owner_d     = pick[1];
          last_d      = pick[1];
          cap_we_d    = pick[1] ? m1_we    : m0_we;
          cap_be_d    = pick[1] ? m1_be    : m0_be;
          cap_addr_d  = pick[1] ? m1_addr  : m0_addr;
          cap_wdata_d = pick[1] ? m1_wdata : m0_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The address stays on the bus after ISSUE so the RAM output stays stable in RESP.
  always_comb begin
    mem_addr  = cap_addr_q;
    mem_wdata = cap_wdata_q;
    mem_be    = (state_q == ISSUE) ? cap_be_q : '0;
    mem_we    = (state_q == ISSUE) && cap_we_q;
    m0_rvalid = (state_q == RESP) && !owner_q;
    m1_rvalid = (state_q == RESP) && owner_q;
    m0_rdata  = (m0_rvalid && !cap_we_q) ? mem_rdata : '0;
    m1_rdata  = (m1_rvalid && !cap_we_q) ? mem_rdata : '0;
  end

endmodule
